// File: rtl/disp_cmd_serializer.sv
// Serial command writer for LED-matrix driver chips: FIFO-buffered words shifted out
// MSB-first on sdo under a divided WR strobe, one active-low chip select per chip.
module disp_cmd_serializer #(
  parameter int WORD_W = 14,
  parameter int NCHIP  = 4,
  parameter int DIV    = 2,
  parameter int DEPTH  = 4,
  localparam int LEN_W  = $clog2(WORD_W + 1),
  localparam int CHIP_W = (NCHIP > 1) ? $clog2(NCHIP) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [CHIP_W-1:0] in_chip,
  input  logic              in_hold,
  output logic [NCHIP-1:0]  cs_n,
  output logic              wr,
  output logic              sdo,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = (DIV >= 2) ? DIV_W'(DIV - 2) : '0;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic [CHIP_W-1:0] chip;
    logic              hold;
  } word_t;

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP} state_t;

  word_t             mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [PTR_W:0]    count;
  word_t             head, in_word;
  logic              full, empty, push, pop;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [LEN_W-1:0]  bit_idx;
  logic [WORD_W-1:0] cur_data;
  logic [CHIP_W-1:0] cur_chip;
  logic              cur_hold;
  logic              phase_end, bit_last, head_ok, merge_now, idle_like;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rptr];
  assign busy     = (state != IDLE) || !empty;

  // Over-long words are clamped once on entry so the FSM only ever sees legal lengths.
  assign in_word.data = in_data;
  assign in_word.len  = (in_len > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : in_len;
  assign in_word.chip = in_chip;
  assign in_word.hold = in_hold;

  assign phase_end = (div_cnt == DIV_LAST);
  assign bit_last  = (bit_idx == '0);
  assign head_ok   = (head.len != '0) && ({1'b0, head.chip} < (CHIP_W+1)'(NCHIP));
  assign merge_now = (state == HIGH) && phase_end && bit_last && cur_hold && !empty
                     && head_ok && (head.chip == cur_chip);
  // The end of GAP acts as IDLE so back-to-back words see exactly DIV cycles of deselect.
  assign idle_like = (state == IDLE) || ((state == GAP) && phase_end);
  assign pop       = !empty && (idle_like || merge_now);

  // NOTE: storage array has no reset; only pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cs_n     <= '1;
      wr       <= 1'b1;
      sdo      <= 1'b0;
      done     <= 1'b0;
      div_cnt  <= '0;
      bit_idx  <= '0;
      cur_data <= '0;
      cur_chip <= '0;
      cur_hold <= 1'b0;
    end else begin
      done    <= 1'b0;
      div_cnt <= (state == IDLE || phase_end) ? '0 : div_cnt + 1'b1;
      case (state)
        IDLE: ;
        SETUP: if (phase_end) begin
          state <= LOW;
          wr    <= 1'b0;
          sdo   <= cur_data[bit_idx];
        end
        LOW: begin
          if (DIV == 1 && phase_end && bit_last) done <= 1'b1;
          if (phase_end) begin
            state <= HIGH;
            wr    <= 1'b1;
          end
        end
        HIGH: begin
          if (DIV >= 2 && div_cnt == DIV_PRE && bit_last) done <= 1'b1;
          if (phase_end) begin
            if (!bit_last) begin
              state   <= LOW;
              wr      <= 1'b0;
              bit_idx <= bit_idx - 1'b1;
              sdo     <= cur_data[bit_idx - 1'b1];
            end else if (merge_now) begin
              state    <= LOW;
              wr       <= 1'b0;
              cur_data <= head.data;
              cur_hold <= head.hold;
              bit_idx  <= head.len - 1'b1;
              sdo      <= head.data[head.len - 1'b1];
            end else begin
              state <= GAP;
              cs_n  <= '1;
              sdo   <= 1'b0;
            end
          end
        end
        GAP: if (phase_end) state <= IDLE;
        default: state <= IDLE;
      endcase
      // Head handling is shared by IDLE and the last GAP cycle; it overrides the case above.
      if (idle_like && !empty) begin
        if (head_ok) begin
          state    <= SETUP;
          cs_n     <= ~(NCHIP'(1) << head.chip);
          wr       <= 1'b1;
          sdo      <= 1'b0;
          cur_data <= head.data;
          cur_chip <= head.chip;
          cur_hold <= head.hold;
          bit_idx  <= head.len - 1'b1;
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_disp_cmd_serializer.sv
// Randomised and directed bench for disp_cmd_serializer; two instances (DIV=2/NCHIP=4 and
// DIV=1/NCHIP=3) share stimulus lines, selected by sel, and are checked against a bit-stream model.
module tb_disp_cmd_serializer;

  localparam int WORD_W = 14;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, v, sel;
  logic [13:0] in_data;
  logic [3:0]  in_len;
  logic [1:0]  in_chip;
  logic        in_hold;

  logic       rdy0, wr0, sdo0, busy0, done0;
  logic [3:0] cs0;
  logic       rdy1, wr1, sdo1, busy1, done1;
  logic [2:0] cs1;

  disp_cmd_serializer #(.WORD_W(14), .NCHIP(4), .DIV(2), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .in_valid(v & ~sel), .in_ready(rdy0), .in_data(in_data),
    .in_len(in_len), .in_chip(in_chip), .in_hold(in_hold), .cs_n(cs0), .wr(wr0),
    .sdo(sdo0), .busy(busy0), .done(done0));

  disp_cmd_serializer #(.WORD_W(14), .NCHIP(3), .DIV(1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v & sel), .in_ready(rdy1), .in_data(in_data),
    .in_len(in_len), .in_chip(in_chip), .in_hold(in_hold), .cs_n(cs1), .wr(wr1),
    .sdo(sdo1), .busy(busy1), .done(done1));

  typedef struct packed {
    logic [3:0] cs_n;
    logic       wr, sdo, busy, done;
  } samp_t;

  typedef struct packed {
    logic [1:0] chip;
    logic       b;
  } bit_t;

  samp_t tr0[$], tr1[$];
  bit_t  exp_q[$], obs_q[$];
  int    low_runs[$], gap_runs[$];
  int    total = 0, bad = 0;
  int    exp_done, obs_done, multi_low, wr_low;

  always @(negedge clk) begin
    tr0.push_back('{cs_n: cs0, wr: wr0, sdo: sdo0, busy: busy0, done: done0});
    tr1.push_back('{cs_n: {1'b1, cs1}, wr: wr1, sdo: sdo1, busy: busy1, done: done1});
  end

  function automatic logic cur_ready();
    return sel ? rdy1 : rdy0;
  endfunction

  function automatic logic cur_busy();
    return sel ? busy1 : busy0;
  endfunction

  task automatic start_test(input logic s);
    sel = s;
    tr0.delete();
    tr1.delete();
    exp_q.delete();
    exp_done = 0;
  endtask

  // Reference: each accepted word yields one done and, if legal, its clamped bits MSB first.
  task automatic model_push(input logic [13:0] d, input int len, input int chip);
    int l;
    int nchip;
    l     = (len > WORD_W) ? WORD_W : len;
    nchip = sel ? 3 : 4;
    exp_done++;
    if (l == 0 || chip >= nchip) return;
    for (int i = l - 1; i >= 0; i--) exp_q.push_back('{chip: 2'(chip), b: d[i]});
  endtask

  task automatic push_word(input logic [13:0] d, input int len, input int chip,
                           input logic hold, output int waited);
    waited = 0;
    @(negedge clk);
    v = 1'b1; in_data = d; in_len = 4'(len); in_chip = 2'(chip); in_hold = hold;
    while (!cur_ready() && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 1000) begin
      total++; bad++;
      $display("FAIL push_timeout: in_ready=%0d want 1", cur_ready());
    end else begin
      @(posedge clk);
      model_push(d, len, chip);
    end
    #1 v = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (cur_busy() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0d want 0", cur_busy());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic analyze();
    samp_t t[$];
    int    run = 0, hi = 0;
    bit    seen_low = 0;
    if (sel) t = tr1; else t = tr0;
    obs_q.delete(); low_runs.delete(); gap_runs.delete();
    obs_done = 0; multi_low = 0; wr_low = 0;
    foreach (t[i]) begin
      int nlow = 0;
      int idx  = 0;
      for (int k = 0; k < 4; k++) if (!t[i].cs_n[k]) begin nlow++; idx = k; end
      if (nlow > 1) multi_low++;
      if (t[i].done) obs_done++;
      if (!t[i].wr) wr_low++;
      if (i > 0 && !t[i-1].wr && t[i].wr) obs_q.push_back('{chip: idx[1:0], b: t[i].sdo});
      if (nlow != 0) begin
        if (run == 0 && seen_low) gap_runs.push_back(hi);
        run++;
        hi = 0;
      end else begin
        if (run > 0) begin low_runs.push_back(run); seen_low = 1; end
        run = 0;
        hi++;
      end
    end
    if (run > 0) low_runs.push_back(run);
  endtask

  function automatic int stream_errs();
    int e = 0;
    if (obs_q.size() != exp_q.size()) e++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic logic [15:0] obs_vec();
    logic [15:0] r = '0;
    foreach (obs_q[i]) r = {r[14:0], obs_q[i].b};
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0; v = 1'b0; sel = 1'b0;
    in_data = '0; in_len = '0; in_chip = '0; in_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({cs0, wr0, sdo0, busy0, done0} !== 8'b1111_1000) begin bad++;
      $display("FAIL reset_pins0: got %b want 11111000", {cs0, wr0, sdo0, busy0, done0}); end
    total++; if ({cs1, wr1, sdo1, busy1, done1} !== 7'b111_1000) begin bad++;
      $display("FAIL reset_pins1: got %b want 1111000", {cs1, wr1, sdo1, busy1, done1}); end
    total++; if ({rdy0, rdy1} !== 2'b11) begin bad++;
      $display("FAIL reset_ready: got %b want 11", {rdy0, rdy1}); end
    reset = 1'b1;
    @(negedge clk);
    total++; if ({rdy0, busy0, cs0} !== 6'b10_1111) begin bad++;
      $display("FAIL post_reset: got %b want 101111", {rdy0, busy0, cs0}); end
  endtask

  task automatic test_single_word();
    int w;
    start_test(1'b0);
    push_word(14'h2A5A, 14, 2, 1'b0, w);
    @(negedge clk);
    total++; if (cs0 !== 4'hF) begin bad++;
      $display("FAIL latency_t1: cs_n=%b want 1111", cs0); end
    @(negedge clk);
    total++; if (cs0 !== 4'b1011) begin bad++;
      $display("FAIL latency_t2: cs_n=%b want 1011", cs0); end
    wait_idle();
    analyze();
    total++; if (obs_vec() !== 16'b0010101001011010 || obs_q.size() != 14) begin bad++;
      $display("FAIL single_bits: got %b (%0d rises) want 10101001011010 (14)", obs_vec(), obs_q.size()); end
    total++; if (stream_errs() !== 0) begin bad++;
      $display("FAIL single_stream: errors=%0d want 0", stream_errs()); end
    total++; if (low_runs.size() != 1 || low_runs[0] != 2 + 4 * 14) begin bad++;
      $display("FAIL single_cs_low: runs=%0d first=%0d want 1 run of %0d",
               low_runs.size(), (low_runs.size() > 0) ? low_runs[0] : -1, 2 + 4 * 14); end
    total++; if (obs_done !== 1) begin bad++;
      $display("FAIL single_done: got %0d want 1", obs_done); end
  endtask

  task automatic test_merge();
    int w;
    start_test(1'b0);
    push_word(14'h00A5, 8, 1, 1'b1, w);
    push_word(14'h003C, 8, 1, 1'b0, w);
    wait_idle();
    analyze();
    total++; if (obs_vec() !== 16'hA53C || obs_q.size() != 16) begin bad++;
      $display("FAIL merge_bits: got %h (%0d rises) want a53c (16)", obs_vec(), obs_q.size()); end
    total++; if (low_runs.size() != 1 || low_runs[0] != 2 + 4 * 16 || gap_runs.size() != 0) begin bad++;
      $display("FAIL merge_cs: runs=%0d first=%0d gaps=%0d want 1 run of %0d, 0 gaps", low_runs.size(),
               (low_runs.size() > 0) ? low_runs[0] : -1, gap_runs.size(), 2 + 4 * 16); end
    total++; if (obs_done !== 2 || stream_errs() !== 0) begin bad++;
      $display("FAIL merge_done_stream: done=%0d errs=%0d want 2/0", obs_done, stream_errs()); end
  endtask

  task automatic test_no_merge();
    int w;
    start_test(1'b0);
    push_word(14'h00A5, 8, 1, 1'b1, w);
    push_word(14'h003C, 8, 3, 1'b0, w);
    wait_idle();
    analyze();
    total++; if (low_runs.size() != 2 || low_runs[0] != 34 || low_runs[1] != 34) begin bad++;
      $display("FAIL nomerge_runs: count=%0d want 2 runs of 34", low_runs.size()); end
    total++; if (gap_runs.size() != 1 || gap_runs[0] != 2) begin bad++;
      $display("FAIL nomerge_gap: count=%0d first=%0d want 1 gap of 2", gap_runs.size(),
               (gap_runs.size() > 0) ? gap_runs[0] : -1); end
    total++; if (obs_done !== 2 || stream_errs() !== 0) begin bad++;
      $display("FAIL nomerge_done_stream: done=%0d errs=%0d want 2/0", obs_done, stream_errs()); end
  endtask

  task automatic test_back_to_back();
    int w;
    int first_stall = -1;
    start_test(1'b0);
    for (int k = 0; k < DEPTH + 2; k++) begin
      push_word(14'($urandom), 8 + $urandom_range(0, 6), $urandom_range(0, 3), 1'b0, w);
      if (w > 0 && first_stall < 0) first_stall = k;
    end
    wait_idle();
    analyze();
    total++; if (first_stall !== DEPTH + 1) begin bad++;
      $display("FAIL b2b_stall: first stalled word=%0d want %0d", first_stall, DEPTH + 1); end
    total++; if (stream_errs() !== 0 || obs_done !== DEPTH + 2) begin bad++;
      $display("FAIL b2b_stream: errs=%0d done=%0d want 0/%0d", stream_errs(), obs_done, DEPTH + 2); end
  endtask

  task automatic test_drop();
    int w;
    start_test(1'b1);
    push_word(14'h1234, 0, 0, 1'b0, w);
    push_word(14'h0FFF, 5, 3, 1'b0, w);
    wait_idle();
    analyze();
    total++; if (obs_done !== 2) begin bad++;
      $display("FAIL drop_done: got %0d want 2", obs_done); end
    total++; if (low_runs.size() != 0 || wr_low != 0) begin bad++;
      $display("FAIL drop_pins: cs_low_runs=%0d wr_low=%0d want 0/0", low_runs.size(), wr_low); end
  endtask

  task automatic test_reset_mid();
    int w;
    int falls = 0;
    int n = 0;
    logic prev = 1'b1;
    start_test(1'b0);
    push_word(14'($urandom), 14, 1, 1'b0, w);
    push_word(14'($urandom), 10, 3, 1'b0, w);
    while (falls < 7 && n < 500) begin
      @(negedge clk);
      if (prev && !wr0) falls++;
      prev = wr0;
      n++;
    end
    total++; if (falls !== 7) begin bad++;
      $display("FAIL midreset_reach: falls=%0d want 7", falls); end
    reset = 1'b0;
    @(negedge clk);
    total++; if ({cs0, wr0, sdo0, busy0} !== 7'b1111_100) begin bad++;
      $display("FAIL midreset_pins: got %b want 1111100", {cs0, wr0, sdo0, busy0}); end
    reset = 1'b1;
    start_test(1'b0);
    push_word(14'($urandom), 9, 0, 1'b0, w);
    wait_idle();
    analyze();
    total++; if (stream_errs() !== 0 || obs_done !== 1) begin bad++;
      $display("FAIL midreset_after: errs=%0d done=%0d want 0/1", stream_errs(), obs_done); end
  endtask

  task automatic test_div1();
    int w;
    start_test(1'b1);
    push_word(14'h2A5A, 14, 2, 1'b0, w);
    push_word(14'h0015, 5, 0, 1'b0, w);
    wait_idle();
    analyze();
    total++; if (low_runs.size() != 2 || low_runs[0] != 29 || low_runs[1] != 11) begin bad++;
      $display("FAIL div1_runs: count=%0d first=%0d want 29 then 11", low_runs.size(),
               (low_runs.size() > 0) ? low_runs[0] : -1); end
    total++; if (gap_runs.size() != 1 || gap_runs[0] != 1) begin bad++;
      $display("FAIL div1_gap: count=%0d want 1 gap of 1", gap_runs.size()); end
    total++; if (stream_errs() !== 0 || obs_done !== 2) begin bad++;
      $display("FAIL div1_stream: errs=%0d done=%0d want 0/2", stream_errs(), obs_done); end
  endtask

  task automatic test_random();
    int w;
    for (int s = 0; s < 2; s++) begin
      start_test(s[0]);
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push_word(14'($urandom), $urandom_range(0, 15), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), w);
      end
      wait_idle();
      analyze();
      total++; if (stream_errs() !== 0) begin bad++;
        $display("FAIL random_stream%0d: errs=%0d got %0d bits want %0d", s, stream_errs(),
                 obs_q.size(), exp_q.size()); end
      total++; if (obs_done !== exp_done) begin bad++;
        $display("FAIL random_done%0d: got %0d want %0d", s, obs_done, exp_done); end
      total++; if (multi_low !== 0) begin bad++;
        $display("FAIL random_onehot%0d: multi-select cycles=%0d want 0", s, multi_low); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_merge();
    test_no_merge();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_div1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
